// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//   Pipelined WIDTH x WIDTH Wallace-tree multiplier with a per-operation
//   signed/unsigned mode and an elastic valid/ready pipeline (1 result/cycle,
//   full backpressure, no skid buffer).
//
//   Datapath: partial products (Baugh-Wooley form in signed mode) are reduced
//   with 3:2 carry-save layers down to two rows, followed by one carry-propagate
//   add. The first stage builds the partial products and runs the first
//   layers. The remaining layers are spread over the middle stages. The last
//   stage does the final add. With PIPE_STAGES=1 the whole tree feeds one
//   output register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (control and output only)
//   in_valid   operand pair a/b/is_signed is valid
//   in_ready   block can accept an operand pair this cycle
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  prod holds a valid result
//   out_ready  downstream accepts prod this cycle
//   prod       2*WIDTH-bit product
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int PW    = 2 * WIDTH;
  // One row per multiplier bit plus one row for the Baugh-Wooley constants.
  localparam int NROWS = WIDTH + 1;

  typedef logic [PW-1:0]             row_t;
  typedef logic [NROWS-1:0][PW-1:0]  rows_t;

  // Rows left after one 3:2 layer: each full group of three becomes two.
  function automatic int next_rows(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int count_layers(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    for (int i = 0; i < NROWS; i++) begin
      if (n > 2) begin
        n = next_rows(n);
        l++;
      end
    end
    return l;
  endfunction

  // Number of live rows entering layer 'layer'.
  function automatic int rows_before(input int layer);
    int n;
    n = NROWS;
    for (int i = 0; i < NROWS; i++) begin
      if (i < layer && n > 2) n = next_rows(n);
    end
    return n;
  endfunction

  localparam int LAYERS  = count_layers(NROWS);
  localparam int TREE_ST = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  // First layer of tree stage s; rounding up front-loads the first stage.
  function automatic int layer_lo(input int s);
    return (s * LAYERS + TREE_ST - 1) / TREE_ST;
  endfunction

  // Partial-product rows. In signed mode the terms pairing exactly one sign
  // bit are inverted and 1s are added at columns WIDTH and 2*WIDTH-1; the
  // result is then the two's-complement product modulo 2^(2*WIDTH).
  function automatic rows_t pp_gen(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic             sgn);
    rows_t r;
    logic  pb;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pb = x[j] & y[i];
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) pb = ~pb;
        r[i][i+j] = pb;
      end
    end
    if (sgn) begin
      r[WIDTH][WIDTH] = 1'b1;
      r[WIDTH][PW-1]  = 1'b1;
    end
    return r;
  endfunction

  // One Wallace layer over n live rows: full adders on each group of three,
  // leftover rows pass straight through. Carries out of the top column are
  // dropped, which is exact modulo 2^(2*WIDTH).
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < NROWS / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) |
                    (r[3*i+1] & r[3*i+2])) << 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (i < n - 3 * g) o[2*g+i] = r[3*g+i];
    end
    return o;
  endfunction

  // Rows beyond the last two are always zero once the tree is complete.
  function automatic row_t cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] vld_d;
  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES-1:0] ld;
  row_t                   prod_d;
  row_t                   prod_q;
  rows_t                  cpa_in;

  // Stage k may advance when downstream accepts or any stage from k onwards
  // holds a bubble; ld[k] additionally needs valid data arriving.
  always_comb begin
    logic                 room;
    logic [PIPE_STAGES:0] up;
    room  = out_ready;
    adv   = '0;
    ld    = '0;
    vld_d = vld_q;
    up    = {vld_q, in_valid};
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      room   = room | ~vld_q[k];
      adv[k] = room;
    end
    for (int k = 0; k < PIPE_STAGES; k++) begin
      if (adv[k]) vld_d[k] = up[k];
      ld[k] = adv[k] & up[k];
    end
  end

  for (genvar s = 0; s < TREE_ST; s++) begin : g_tree
    localparam int LO = layer_lo(s);
    localparam int HI = layer_lo(s + 1);
    rows_t st_in;
    rows_t st_d;

    if (s == 0) begin : g_src
      assign st_in = pp_gen(a, b, is_signed);
    end else begin : g_src
      assign st_in = g_tree[s-1].g_reg.st_q;
    end

    always_comb begin
      st_d = st_in;
      for (int l = LO; l < HI; l++) st_d = csa_layer(st_d, rows_before(l));
    end

    // ---- stage boundary: carry-save rows registered after tree stage s ----
    if (PIPE_STAGES > 1) begin : g_reg
      rows_t st_q;
      always_ff @(posedge clk) begin
        if (ld[s]) st_q <= st_d;
      end
    end
  end

  if (PIPE_STAGES > 1) begin : g_cpa_src
    assign cpa_in = g_tree[TREE_ST-1].g_reg.st_q;
  end else begin : g_cpa_src
    assign cpa_in = g_tree[0].st_d;
  end

  always_comb begin
    prod_d = cpa(cpa_in);
  end

  // ---- stage boundary: output register and all valid bits ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      prod_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (ld[PIPE_STAGES-1]) prod_q <= prod_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[PIPE_STAGES-1];
  assign prod      = prod_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_wallace_mult_pipe
//   Self-checking bench for wallace_mult_pipe (WIDTH=8, PIPE_STAGES=3).
//   Expected products come from plain integer multiplication of the operands
//   as accepted at the input handshake, kept in an in-order queue.
// -----------------------------------------------------------------------------
module tb_wallace_mult_pipe;

  localparam int W  = 8;
  localparam int PS = 3;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          is_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] prod;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [PW-1:0] exp_q[$];

  typedef struct {
    bit            in_hs;
    bit            out_hs;
    bit            none;
    bit            rdy;
    bit            ov;
    logic [PW-1:0] got;
    logic [PW-1:0] want;
    int            occ;
  } obs_t;

  wallace_mult_pipe #(.WIDTH(W), .PIPE_STAGES(PS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic         s);
    longint xi, yi, p;
    if (s) begin
      xi = longint'($signed(x));
      yi = longint'($signed(y));
    end else begin
      xi = longint'(x);
      yi = longint'(y);
    end
    p = xi * yi;
    return p[PW-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h80;
      3:       return 8'h7F;
      4:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Observe one cycle at the falling edge (the handshakes that the next
  // rising edge will perform), update the model queue, step past the edge.
  task automatic tick(output obs_t o);
    @(negedge clk);
    o.occ    = exp_q.size();
    o.rdy    = in_ready;
    o.ov     = out_valid;
    o.in_hs  = in_valid && in_ready;
    o.out_hs = out_valid && out_ready;
    o.got    = prod;
    o.want   = '0;
    o.none   = 1'b0;
    if (o.out_hs) begin
      if (exp_q.size() == 0) o.none = 1'b1;
      else o.want = exp_q.pop_front();
    end
    if (o.in_hs) exp_q.push_back(ref_mul(a, b, is_signed));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (prod !== '0) begin bad++; $display("FAIL reset_prod got=%h want=0000", prod); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_unsigned_max();
    obs_t o;
    int   t_in;
    int   t_out;
    logic [PW-1:0] res;
    t_out = -1;
    res = '0;
    out_ready = 1'b1;
    a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
    tick(o);
    t_in = cyc;
    in_valid = 1'b0;
    total++;
    if (!o.in_hs) begin bad++; $display("FAIL umax_accept got=%b want=1", o.in_hs); end
    for (int i = 0; i < 12 && t_out < 0; i++) begin
      tick(o);
      if (o.out_hs) begin t_out = cyc; res = o.got; end
    end
    total++;
    if (t_out < 0) begin
      bad++; $display("FAIL umax_timeout got=no_result want=result");
    end else begin
      total++;
      if (t_out - t_in != PS) begin bad++; $display("FAIL umax_latency got=%0d want=%0d", t_out - t_in, PS); end
      if (res !== 16'hFE01) begin bad++; $display("FAIL umax_prod got=%h want=fe01", res); end
    end
  endtask

  task automatic test_signed_b2b();
    logic [W-1:0]  ta[3] = '{8'h80, 8'hFF, 8'h7F};
    logic [W-1:0]  tb[3] = '{8'h80, 8'h01, 8'h80};
    logic [PW-1:0] te[3] = '{16'h4000, 16'hFFFF, 16'hC080};
    obs_t o;
    int sent, rcv, first;
    sent = 0; rcv = 0; first = -1;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && rcv < 3; t++) begin
      if (sent < 3) begin
        in_valid = 1'b1; a = ta[sent]; b = tb[sent]; is_signed = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(o);
      if (o.in_hs) sent++;
      if (o.out_hs) begin
        total++;
        if (o.got !== te[rcv]) begin bad++; $display("FAIL signed_prod[%0d] got=%h want=%h", rcv, o.got, te[rcv]); end
        if (rcv == 0) first = cyc;
        else begin
          total++;
          if (cyc != first + rcv) begin bad++; $display("FAIL signed_consecutive[%0d] got_cycle=%0d want_cycle=%0d", rcv, cyc, first + rcv); end
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (rcv != 3) begin bad++; $display("FAIL signed_count got=%0d want=3", rcv); end
  endtask

  task automatic test_mixed_mode();
    logic          ts[2] = '{1'b0, 1'b1};
    logic [PW-1:0] te[2] = '{16'h01FE, 16'hFFFE};
    obs_t o;
    int sent, rcv;
    sent = 0; rcv = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && rcv < 2; t++) begin
      if (sent < 2) begin
        in_valid = 1'b1; a = 8'hFF; b = 8'h02; is_signed = ts[sent];
      end else begin
        in_valid = 1'b0;
      end
      tick(o);
      if (o.in_hs) sent++;
      if (o.out_hs) begin
        total++;
        if (o.got !== te[rcv]) begin bad++; $display("FAIL mixed_prod[%0d] got=%h want=%h", rcv, o.got, te[rcv]); end
        rcv++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (rcv != 2) begin bad++; $display("FAIL mixed_count got=%0d want=2", rcv); end
  endtask

  task automatic test_stall();
    obs_t o;
    int sent, rcv, low, first_low;
    bit stalled_prev;
    logic [PW-1:0] held;
    sent = 0; rcv = 0; low = 0; first_low = -1;
    stalled_prev = 1'b0; held = '0;
    for (int t = 0; t < 80 && rcv < 10; t++) begin
      in_valid  = (sent < 10);
      a = pick(); b = pick(); is_signed = 1'($urandom_range(0, 1));
      out_ready = !(t >= 4 && t <= 8);
      tick(o);
      if (o.in_hs) sent++;
      if (in_valid && !o.rdy) begin
        low++;
        if (first_low < 0) first_low = t;
      end
      if (stalled_prev) begin
        total++;
        if (!o.ov || o.got !== held) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/%h", o.ov, o.got, held); end
      end
      stalled_prev = o.ov && !out_ready;
      held = o.got;
      if (o.out_hs) begin
        total++;
        if (o.none || o.got !== o.want) begin bad++; $display("FAIL stall_prod[%0d] got=%h want=%h", rcv, o.got, o.want); end
        rcv++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcv != 10) begin bad++; $display("FAIL stall_count got=%0d want=10", rcv); end
    total++;
    if (low != 5) begin bad++; $display("FAIL stall_in_ready_low_cycles got=%0d want=5", low); end
    total++;
    if (first_low != 4) begin bad++; $display("FAIL stall_in_ready_first_low got=%0d want=4", first_low); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int sent, rcv;
    sent = 0; rcv = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = pick(); b = pick(); is_signed = 1'($urandom_range(0, 1));
      tick(o);
      if (o.in_hs) sent++;
    end
    in_valid = 1'b0;
    total++;
    if (sent != 3) begin bad++; $display("FAIL rstmid_accepts got=%0d want=3", sent); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++;
    if (prod !== '0) begin bad++; $display("FAIL rstmid_prod got=%h want=0000", prod); end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(o);
      total++;
      if (o.ov !== 1'b0) begin bad++; $display("FAIL rstmid_stale[%0d] got=%b want=0", i, o.ov); end
    end
    sent = 0;
    for (int t = 0; t < 15 && rcv < 1; t++) begin
      in_valid = (sent < 1); a = 8'h9C; b = 8'h07; is_signed = 1'b1;
      tick(o);
      if (o.in_hs) sent++;
      if (o.out_hs) begin
        total++;
        if (o.got !== 16'hFD44) begin bad++; $display("FAIL rstmid_after got=%h want=fd44", o.got); end
        rcv++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (rcv != 1) begin bad++; $display("FAIL rstmid_after_count got=%0d want=1", rcv); end
  endtask

  task automatic test_random();
    localparam int N = 3000;
    obs_t o;
    int sent, rcv;
    bit stalled_prev, exp_rdy;
    logic [PW-1:0] held;
    sent = 0; rcv = 0; stalled_prev = 1'b0; held = '0;
    for (int t = 0; t < 20000 && rcv < N; t++) begin
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      out_ready = (sent >= N) || ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); is_signed = 1'($urandom_range(0, 1));
      tick(o);
      if (o.in_hs) sent++;
      exp_rdy = !(o.occ == PS && !out_ready);
      total++;
      if (o.rdy !== exp_rdy) begin bad++; $display("FAIL rand_in_ready t=%0d got=%b want=%b", t, o.rdy, exp_rdy); end
      if (stalled_prev) begin
        total++;
        if (!o.ov || o.got !== held) begin bad++; $display("FAIL rand_hold t=%0d got=%b/%h want=1/%h", t, o.ov, o.got, held); end
      end
      stalled_prev = o.ov && !out_ready;
      held = o.got;
      if (o.out_hs) begin
        total++;
        if (o.none || o.got !== o.want) begin bad++; $display("FAIL rand_prod[%0d] got=%h want=%h", rcv, o.got, o.want); end
        rcv++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (rcv != N) begin bad++; $display("FAIL rand_count got=%0d want=%0d", rcv, N); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_b2b();
    test_mixed_mode();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
